// File: rtl/hack_control_unit.sv
// hack_control_unit
//   Multi-cycle fetch/decode/execute controller for the Hack CPU. Owns the
//   A, D and PC registers plus the internal IR, MDR and R (latched ALU
//   result) registers. It sequences the instruction- and data-memory
//   handshakes and drives the operand/control inputs of an external ALU,
//   whose zr/ng flags decide conditional jumps.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   run                      allow a new instruction fetch
//   imem_req/addr/ack/data   instruction read handshake (addr = PC)
//   dmem_req/we/addr/wdata   data memory request (addr = A, wdata = R)
//   dmem_ack/rdata           data memory completion / read data
//   alu_x, alu_y             ALU operands (D, and MDR or A)
//   alu_zx..alu_no           ALU control bits (IR[11:6] for C-instructions)
//   alu_out, alu_zr, alu_ng  ALU result and flags
//   pc_out                   current PC
//   instr_done               one-cycle pulse when an instruction retires
//
// Instruction flow
//   A-instr : FETCH -> DECODE
//   C-instr : FETCH -> DECODE -> [MEMRD] -> EXEC -> [MEMWR] -> COMMIT
module hack_control_unit #(
  parameter int          WIDTH    = 16,
  parameter int          AW       = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [AW-1:0]    dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic [AW-1:0]    pc_out,
  output logic             instr_done
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_MEMWR,
    S_COMMIT
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    pc_reg, pc_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] ir_reg, ir_next;
  logic [WIDTH-1:0] mdr_reg, mdr_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             zr_reg, zr_next;
  logic             ng_reg, ng_next;
  // Set once a fetch request has been raised but not yet acknowledged, so a
  // later drop of run cannot withdraw a request that is already visible.
  logic             imem_pend_reg, imem_pend_next;
  logic             jump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_FETCH;
      pc_reg        <= AW'(RESET_PC);
      a_reg         <= '0;
      d_reg         <= '0;
      ir_reg        <= '0;
      mdr_reg       <= '0;
      r_reg         <= '0;
      zr_reg        <= 1'b0;
      ng_reg        <= 1'b0;
      imem_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      a_reg         <= a_next;
      d_reg         <= d_next;
      ir_reg        <= ir_next;
      mdr_reg       <= mdr_next;
      r_reg         <= r_next;
      zr_reg        <= zr_next;
      ng_reg        <= ng_next;
      imem_pend_reg <= imem_pend_next;
    end
  end

  // Jump condition from the flags latched in EXEC (j1 = NG, j2 = ZR, j3 = positive).
  assign jump = (ir_reg[2] & ng_reg) | (ir_reg[1] & zr_reg) | (ir_reg[0] & ~ng_reg & ~zr_reg);

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    a_next         = a_reg;
    d_next         = d_reg;
    ir_next        = ir_reg;
    mdr_next       = mdr_reg;
    r_next         = r_reg;
    zr_next        = zr_reg;
    ng_next        = ng_reg;
    imem_pend_next = imem_pend_reg;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    instr_done     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        imem_req = run | imem_pend_reg;
        if (imem_req) begin
          if (imem_ack) begin
            ir_next        = imem_data;
            imem_pend_next = 1'b0;
            state_next     = S_DECODE;
          end else begin
            imem_pend_next = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (!ir_reg[WIDTH-1]) begin
          // A-instruction: zero-extended immediate, IR[14:13] are part of it.
          a_next     = {{(WIDTH-AW){1'b0}}, ir_reg[AW-1:0]};
          pc_next    = pc_reg + AW'(1);
          instr_done = 1'b1;
          state_next = S_FETCH;
        end else if (ir_reg[12]) begin
          state_next = S_MEMRD;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_MEMRD: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          mdr_next   = dmem_rdata;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        r_next     = alu_out;
        zr_next    = alu_zr;
        ng_next    = alu_ng;
        state_next = ir_reg[3] ? S_MEMWR : S_COMMIT;
      end
      S_MEMWR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ack) begin
          state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (ir_reg[5]) a_next = r_reg;
        if (ir_reg[4]) d_next = r_reg;
        // a_reg still holds the pre-commit A, so an AJ-style instruction
        // jumps to the old address even when it also loads A.
        pc_next    = jump ? a_reg[AW-1:0] : pc_reg + AW'(1);
        instr_done = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  assign imem_addr  = pc_reg;
  assign pc_out     = pc_reg;
  assign dmem_addr  = a_reg[AW-1:0];
  assign dmem_wdata = r_reg;
  assign alu_x      = d_reg;
  assign alu_y      = ir_reg[12] ? mdr_reg : a_reg;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} =
      ir_reg[WIDTH-1] ? ir_reg[11:6] : 6'b000000;

endmodule

// File: tb/tb_hack_control_unit.sv
// Testbench for hack_control_unit: memory responders with random stalls and
// spurious acks, an external ALU, and an instruction-level Hack reference
// model whose expectations are queued when each instruction is fetched and
// checked when the DUT retires it or touches data memory.
module tb_hack_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [14:0] imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata = 16'h0;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] pc_out;
  logic        instr_done;

  hack_control_unit #(.WIDTH(16), .AW(15), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc_out(pc_out), .instr_done(instr_done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        is_a;
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
  } mop_t;

  exp_t        exp_q[$];
  mop_t        mop_q[$];
  logic [15:0] forced_q[$];
  logic [15:0] mem[0:32767];
  logic [15:0] ref_mem[0:32767];
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d;
  int          tests = 0, fails = 0, retired = 0, cyc = 0, fetch_cyc = 0;
  logic        run_level = 1'b0, rand_run = 1'b0, stall_en = 1'b0, dmem_hold = 1'b0;

  always_ff @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? 16'(xx + yy) : (xx & yy);
    return c[0] ? ~o : o;
  endfunction

  // External ALU seen by the DUT.
  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    alu_zr  = (alu_out == 16'h0);
    alu_ng  = alu_out[15];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    if ($urandom_range(0, 2) == 0)
      return {1'b0, 15'($urandom)};
    return {1'b1, 2'($urandom), 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
  endfunction

  // Instruction-level Hack semantics: one call per fetched instruction.
  task automatic model_exec(input logic [15:0] ins);
    logic [15:0] a_old, y, o;
    logic        j;
    exp_t        e;
    a_old = m_a;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = 15'(m_pc + 15'd1);
    end else begin
      y = ins[12] ? ref_mem[a_old[14:0]] : a_old;
      if (ins[12]) mop_q.push_back('{we: 1'b0, addr: a_old[14:0], data: 16'h0});
      o = hack_alu(m_d, y, ins[11:6]);
      if (ins[3]) begin
        ref_mem[a_old[14:0]] = o;
        mop_q.push_back('{we: 1'b1, addr: a_old[14:0], data: o});
      end
      j = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) || (ins[0] && $signed(o) > 0);
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
      m_pc = j ? a_old[14:0] : 15'(m_pc + 15'd1);
    end
    e = '{is_a: !ins[15], pc: m_pc, a: m_a, d: m_d};
    exp_q.push_back(e);
  endtask

  // Memory responders and run driver. Acts 1 time unit after the falling edge
  // so that the DUT's combinational request already reflects the new run.
  initial begin : responder
    logic        ib, db, d_we0;
    int          iw, dw;
    logic [15:0] ins, d_wd0;
    logic [14:0] i_addr0, d_addr0;
    mop_t        mexp;
    ib = 1'b0; db = 1'b0; iw = 0; dw = 0; ins = 16'h0;
    i_addr0 = 15'h0; d_addr0 = 15'h0; d_wd0 = 16'h0; d_we0 = 1'b0;
    forever begin
      @(negedge clk);
      run = rand_run ? ($urandom_range(0, 3) != 0) : run_level;
      #1;
      if (rst) begin
        imem_ack = 1'b0; dmem_ack = 1'b0; ib = 1'b0; db = 1'b0;
        exp_q.delete(); mop_q.delete();
        m_pc = 15'h0; m_a = 16'h0; m_d = 16'h0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = mem[i];
      end else begin
        // instruction memory
        if (imem_req) begin
          if (!ib) begin
            ib = 1'b1;
            iw = stall_en ? $urandom_range(0, 3) : 0;
            ins = (forced_q.size() > 0) ? forced_q.pop_front() : rand_instr();
            i_addr0 = imem_addr;
            check("fetch_pc", {1'b0, imem_addr}, {1'b0, m_pc});
            model_exec(ins);
          end else begin
            check("imem_addr_stable", {1'b0, imem_addr}, {1'b0, i_addr0});
          end
          if (iw == 0) begin
            imem_ack = 1'b1; imem_data = ins; ib = 1'b0; fetch_cyc = cyc;
          end else begin
            iw--; imem_ack = 1'b0; imem_data = 16'($urandom);
          end
        end else begin
          imem_ack  = ($urandom_range(0, 7) == 0);
          imem_data = 16'($urandom);
        end
        // data memory
        if (dmem_req) begin
          if (!db) begin
            db = 1'b1;
            dw = stall_en ? $urandom_range(0, 3) : 0;
            if (mop_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL dmem_unexpected: got request we=%b addr=%h, expected none", dmem_we, dmem_addr);
            end else begin
              mexp = mop_q.pop_front();
              check("dmem_we", {15'h0, dmem_we}, {15'h0, mexp.we});
              check("dmem_addr", {1'b0, dmem_addr}, {1'b0, mexp.addr});
              if (mexp.we) check("dmem_wdata", dmem_wdata, mexp.data);
            end
            d_addr0 = dmem_addr; d_wd0 = dmem_wdata; d_we0 = dmem_we;
          end else begin
            check("dmem_addr_stable", {1'b0, dmem_addr}, {1'b0, d_addr0});
            check("dmem_we_stable", {15'h0, dmem_we}, {15'h0, d_we0});
            if (d_we0) check("dmem_wdata_stable", dmem_wdata, d_wd0);
          end
          if (dw == 0 && !dmem_hold) begin
            dmem_ack = 1'b1;
            if (dmem_we) mem[dmem_addr] = dmem_wdata;
            dmem_rdata = mem[dmem_addr];
            db = 1'b0;
          end else begin
            if (dw > 0) dw--;
            dmem_ack = 1'b0; dmem_rdata = 16'($urandom);
          end
        end else begin
          dmem_ack   = ($urandom_range(0, 7) == 0);
          dmem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Retirement monitor: compares architectural state one edge after instr_done.
  initial begin : monitor
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (instr_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL retire_unexpected: got instr_done, expected no instruction in flight");
        end else begin
          e = exp_q.pop_front();
          lat = cyc - fetch_cyc;
          if (e.is_a) check("a_instr_latency", 16'(lat), 16'd1);
          @(negedge clk);
          check("pc", {1'b0, pc_out}, {1'b0, e.pc});
          check("reg_a", {1'b0, dmem_addr}, {1'b0, e.a[14:0]});
          check("reg_d", alu_x, e.d);
          retired++;
          $display("[TB] retire %0d: pc=%h a=%h d=%h (expected pc=%h a=%h d=%h)",
                   retired, pc_out, dmem_addr, alu_x, e.pc, e.a, e.d);
        end
      end
    end
  end

  task automatic wait_retired(input int target, input int budget, input string name);
    int k = 0;
    while (retired < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 16'(retired < target), 16'd0);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin : main
    int base, k;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[7] = 16'h0003;
    repeat (3) @(negedge clk);
    check("rst_imem_req", {15'h0, imem_req}, 16'h0);
    check("rst_dmem_req", {15'h0, dmem_req}, 16'h0);
    check("rst_instr_done", {15'h0, instr_done}, 16'h0);
    check("rst_pc", {1'b0, pc_out}, 16'h0);
    check("rst_d", alu_x, 16'h0);
    check("rst_a", {1'b0, dmem_addr}, 16'h0);

    // Directed program: A-instr, D=A+1, M=D, AM=M-1, D=0;JEQ, D=1;JLT, 0;JMP.
    forced_q = '{16'h1234, 16'h0005, 16'hEDD0, 16'hE308, 16'h0007, 16'hFCA8,
                 16'hEA90, 16'h0040, 16'hE302, 16'hEFD0, 16'hE304, 16'hEA87};
    rst = 1'b0;
    run_level = 1'b1;
    wait_retired(12, 600, "directed_timeout");
    run_level = 1'b0;
    drain("directed_drain");

    // Reset during a stalled M write.
    forced_q = '{16'h0009, 16'hE308};
    dmem_hold = 1'b1;
    run_level = 1'b1;
    k = 0;
    while (!(dmem_req && dmem_we) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("memwr_reached", {15'h0, dmem_req & dmem_we}, 16'h1);
    run_level = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dmem_req", {15'h0, dmem_req}, 16'h0);
    check("async_rst_dmem_we", {15'h0, dmem_we}, 16'h0);
    @(negedge clk);
    check("rst2_pc", {1'b0, pc_out}, 16'h0);
    check("rst2_a", {1'b0, dmem_addr}, 16'h0);
    check("rst2_d", alu_x, 16'h0);
    dmem_hold = 1'b0;
    forced_q.delete();
    @(negedge clk);
    forced_q = '{16'h7FFF, 16'hEA87, 16'h0001, 16'h0002};
    rst = 1'b0;
    base = retired;
    run_level = 1'b1;
    wait_retired(base + 4, 200, "wrap_timeout");
    run_level = 1'b0;
    drain("wrap_drain");

    // Idle with run low: no fetch request.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_no_req", {15'h0, imem_req}, 16'h0);
    end

    // Random program with stalls, spurious acks and a toggling run.
    stall_en = 1'b1;
    rand_run = 1'b1;
    run_level = 1'b1;
    base = retired;
    wait_retired(base + 300, 20000, "random_timeout");
    rand_run = 1'b0;
    run_level = 1'b0;
    drain("random_drain");
    check("mop_queue_empty", 16'(mop_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
